// File: rtl/rv_instr_encoder_if.sv
// Field-bundle handshake between a program source and the instruction encoder.
// The source drives the decoded fields plus in_valid; the encoder answers with in_ready.
interface rv_instr_encoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  fmt;
  logic [6:0]  op;
  logic [2:0]  funct3;
  logic        funct7b5;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [31:0] imm;

  modport master (
    output in_valid, fmt, op, funct3, funct7b5, rd, rs1, rs2, imm,
    input  in_ready
  );

  modport slave (
    input  in_valid, fmt, op, funct3, funct7b5, rd, rs1, rs2, imm,
    output in_ready
  );
endinterface

// File: rtl/rv_instr_encoder.sv
// RV32 instruction encoder / program loader.
// Packs field bundles into 32-bit instruction words and streams them into
// consecutive instruction-memory words, one per cycle, during a load session.
module rv_instr_encoder #(
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              finish,
  rv_instr_encoder_if.slave bus,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [ADDR_W:0]   count,
  output logic              busy,
  output logic              full,
  output logic              err
);

  localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] LAST  = DEPTH - 1'b1;
  localparam logic [31:0]     NOP   = 32'h0000_0013;

  localparam logic [2:0] FMT_I = 3'b000;
  localparam logic [2:0] FMT_S = 3'b001;
  localparam logic [2:0] FMT_B = 3'b010;
  localparam logic [2:0] FMT_J = 3'b011;
  localparam logic [2:0] FMT_U = 3'b100;
  localparam logic [2:0] FMT_R = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    FULL = 2'd2
  } state_t;

  state_t state;
  state_t next_state;

  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W:0]   cnt;
  logic              err_q;
  logic              vld_p0;
  logic              last_p0;
  logic              vld_p1;
  logic [ADDR_W-1:0] addr_p1;
  logic [31:0]       wdata_p1;

  // Formats 110 and 111 have no encoding; they are written as a NOP.
  function automatic logic is_illegal(input logic [2:0] f);
    return f[2] & f[1];
  endfunction

  // Word counter that holds once the memory has been filled.
  function automatic logic [ADDR_W:0] sat_inc(input logic [ADDR_W:0] c);
    return (c == DEPTH) ? c : c + 1'b1;
  endfunction

  // Field packing; B/J immediates are byte offsets so bit 0 is dropped.
  function automatic logic [31:0] encode(
    input logic [2:0]  f,
    input logic [6:0]  o,
    input logic [2:0]  f3,
    input logic        f7b5,
    input logic [4:0]  d,
    input logic [4:0]  s1,
    input logic [4:0]  s2,
    input logic [31:0] im
  );
    logic [31:0] w;
    w = NOP;
    case (f)
      FMT_R:   w = {1'b0, f7b5, 5'b0, s2, s1, f3, d, o};
      FMT_I:   w = {im[11:0], s1, f3, d, o};
      FMT_S:   w = {im[11:5], s2, s1, f3, im[4:0], o};
      FMT_B:   w = {im[12], im[10:5], s2, s1, f3, im[4:1], im[11], o};
      FMT_J:   w = {im[20], im[10:1], im[11], im[19:12], d, o};
      FMT_U:   w = {im[31:12], d, o};
      default: w = NOP;
    endcase
    return w;
  endfunction

  // Stage p0: handshake acceptance of the incoming bundle
  assign bus.in_ready = (state == LOAD);
  assign vld_p0       = bus.in_valid & (state == LOAD);
  assign last_p0      = vld_p0 & (cnt == LAST);

  // Session state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic; start always wins, finish beats the fill-up transition.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (start) next_state = LOAD;
      end
      LOAD: begin
        if (start)        next_state = LOAD;
        else if (finish)  next_state = IDLE;
        else if (last_p0) next_state = FULL;
      end
      FULL: begin
        if (start)       next_state = LOAD;
        else if (finish) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Write pointer, word count and sticky illegal-format flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr   <= '0;
      cnt   <= '0;
      err_q <= 1'b0;
    end else if (start) begin
      ptr   <= '0;
      cnt   <= '0;
      err_q <= 1'b0;
    end else if (vld_p0) begin
      ptr <= ptr + 1'b1;
      cnt <= sat_inc(cnt);
      if (is_illegal(bus.fmt)) err_q <= 1'b1;
    end
  end

  // Stage p1: registered memory write port, one cycle after acceptance
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p1   <= 1'b0;
      addr_p1  <= '0;
      wdata_p1 <= '0;
    end else begin
      vld_p1 <= vld_p0;
      if (vld_p0) begin
        addr_p1  <= ptr;
        wdata_p1 <= encode(bus.fmt, bus.op, bus.funct3, bus.funct7b5,
                           bus.rd, bus.rs1, bus.rs2, bus.imm);
      end
    end
  end

  assign mem_we    = vld_p1;
  assign mem_addr  = addr_p1;
  assign mem_wdata = wdata_p1;
  assign count     = cnt;
  assign err       = err_q;
  assign busy      = (state != IDLE);
  assign full      = (state == FULL);

endmodule

// File: tb/tb_rv_instr_encoder.sv
// Bench for rv_instr_encoder: directed bundles with hand-encoded words, a
// scoreboard queue per instance and a monitor that checks every memory write.
module tb_rv_instr_encoder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        start;
  logic        finish;
  logic        sel;
  logic        vld;
  logic [2:0]  fmt;
  logic [6:0]  op;
  logic [2:0]  funct3;
  logic        funct7b5;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [31:0] imm;

  rv_instr_encoder_if ifa ();
  rv_instr_encoder_if ifb ();

  assign ifa.in_valid = vld & ~sel;
  assign ifb.in_valid = vld & sel;
  assign ifa.fmt = fmt;           assign ifb.fmt = fmt;
  assign ifa.op = op;             assign ifb.op = op;
  assign ifa.funct3 = funct3;     assign ifb.funct3 = funct3;
  assign ifa.funct7b5 = funct7b5; assign ifb.funct7b5 = funct7b5;
  assign ifa.rd = rd;             assign ifb.rd = rd;
  assign ifa.rs1 = rs1;           assign ifb.rs1 = rs1;
  assign ifa.rs2 = rs2;           assign ifb.rs2 = rs2;
  assign ifa.imm = imm;           assign ifb.imm = imm;

  logic        we_a, busy_a, full_a, err_a;
  logic [5:0]  addr_a;
  logic [31:0] wd_a;
  logic [6:0]  cnt_a;
  logic        we_b, busy_b, full_b, err_b;
  logic [1:0]  addr_b;
  logic [31:0] wd_b;
  logic [2:0]  cnt_b;

  rv_instr_encoder #(.ADDR_W(6)) dut_a (
    .clk(clk), .reset(reset), .start(start & ~sel), .finish(finish & ~sel),
    .bus(ifa), .mem_we(we_a), .mem_addr(addr_a), .mem_wdata(wd_a),
    .count(cnt_a), .busy(busy_a), .full(full_a), .err(err_a)
  );

  rv_instr_encoder #(.ADDR_W(2)) dut_b (
    .clk(clk), .reset(reset), .start(start & sel), .finish(finish & sel),
    .bus(ifb), .mem_we(we_b), .mem_addr(addr_b), .mem_wdata(wd_b),
    .count(cnt_b), .busy(busy_b), .full(full_b), .err(err_b)
  );

  logic        cur_we, cur_busy, cur_full, cur_err, cur_rdy;
  logic [31:0] cur_cnt;
  assign cur_we   = sel ? we_b   : we_a;
  assign cur_busy = sel ? busy_b : busy_a;
  assign cur_full = sel ? full_b : full_a;
  assign cur_err  = sel ? err_b  : err_a;
  assign cur_rdy  = sel ? ifb.in_ready : ifa.in_ready;
  assign cur_cnt  = sel ? 32'(cnt_b) : 32'(cnt_a);

  int checks = 0;
  int errors = 0;
  int ptr_a = 0;
  int ptr_b = 0;
  logic [63:0] qa[$];
  logic [63:0] qb[$];
  logic [63:0] ea;
  logic [63:0] eb;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
    end
  endtask

  // Monitor for instance A: every write must match the oldest expected word.
  always @(negedge clk) begin
    if (we_a === 1'b1) begin
      if (qa.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL a_unexpected_write: got addr %0d data 0x%08h, required no write", addr_a, wd_a);
      end else begin
        ea = qa.pop_front();
        chk("a_addr", 32'(addr_a), ea[63:32]);
        chk("a_wdata", wd_a, ea[31:0]);
      end
    end
  end

  // Monitor for instance B.
  always @(negedge clk) begin
    if (we_b === 1'b1) begin
      if (qb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL b_unexpected_write: got addr %0d data 0x%08h, required no write", addr_b, wd_b);
      end else begin
        eb = qb.pop_front();
        chk("b_addr", 32'(addr_b), eb[63:32]);
        chk("b_wdata", wd_b, eb[31:0]);
      end
    end
  end

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    if (sel) ptr_b = 0;
    else     ptr_a = 0;
  endtask

  task automatic pulse_finish();
    finish = 1'b1;
    @(posedge clk);
    @(negedge clk);
    finish = 1'b0;
  endtask

  // Present a bundle (in_valid left high), wait boundedly for acceptance,
  // queue the expected word and confirm the write lands on the next cycle.
  task automatic send(input string name, input logic [2:0] f, input logic [6:0] o,
                      input logic [2:0] f3, input logic f7, input logic [4:0] d,
                      input logic [4:0] s1, input logic [4:0] s2,
                      input logic [31:0] im, input logic [31:0] exp);
    bit ok;
    fmt = f; op = o; funct3 = f3; funct7b5 = f7; rd = d; rs1 = s1; rs2 = s2; imm = im;
    vld = 1'b1;
    ok = 1'b0;
    for (int n = 0; n < 20; n++) begin
      if (cur_rdy === 1'b1) begin
        if (sel) begin
          qb.push_back({32'(ptr_b), exp});
          ptr_b = (ptr_b + 1) % 4;
        end else begin
          qa.push_back({32'(ptr_a), exp});
          ptr_a = (ptr_a + 1) % 64;
        end
        ok = 1'b1;
        @(posedge clk);
        @(negedge clk);
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL %s_accept_timeout: got in_ready=0 for 20 cycles, required acceptance", name);
    end else begin
      chk({name, "_we"}, 32'(cur_we), 32'd1);
    end
  endtask

  logic [31:0] fill_exp [4] = '{32'h0000_0093, 32'h0010_0113, 32'h0020_0193, 32'h0030_0213};

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of stimulus, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; start = 1'b0; finish = 1'b0; sel = 1'b0; vld = 1'b0;
    fmt = '0; op = '0; funct3 = '0; funct7b5 = 1'b0; rd = '0; rs1 = '0; rs2 = '0; imm = '0;
    repeat (2) @(negedge clk);

    // Reset state of both instances.
    chk("rst_a_we", 32'(we_a), 0);       chk("rst_a_addr", 32'(addr_a), 0);
    chk("rst_a_wdata", wd_a, 0);         chk("rst_a_count", 32'(cnt_a), 0);
    chk("rst_a_busy", 32'(busy_a), 0);   chk("rst_a_full", 32'(full_a), 0);
    chk("rst_a_err", 32'(err_a), 0);     chk("rst_a_ready", 32'(ifa.in_ready), 0);
    chk("rst_b_we", 32'(we_b), 0);       chk("rst_b_busy", 32'(busy_b), 0);
    chk("rst_b_count", 32'(cnt_b), 0);   chk("rst_b_ready", 32'(ifb.in_ready), 0);
    reset = 1'b0;
    @(negedge clk);

    // start and finish together: start wins.
    start = 1'b1; finish = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; finish = 1'b0; ptr_a = 0;
    chk("start_wins_busy", 32'(cur_busy), 1);
    pulse_finish();
    chk("idle_busy", 32'(cur_busy), 0);

    // Session on the 64-word instance.
    pulse_start();
    chk("load_busy", 32'(cur_busy), 1);
    chk("load_ready", 32'(cur_rdy), 1);
    chk("load_count0", cur_cnt, 0);
    send("addi", 3'b000, 7'b0010011, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5, 32'h0050_0093);
    vld = 1'b0;
    chk("count_after_first", cur_cnt, 1);

    send("add",  3'b101, 7'b0110011, 3'b000, 1'b0, 5'd3, 5'd1, 5'd2, 32'hDEAD_BEEF, 32'h0020_81B3);
    send("sub",  3'b101, 7'b0110011, 3'b000, 1'b1, 5'd3, 5'd1, 5'd2, 32'h0, 32'h4020_81B3);
    send("sw",   3'b001, 7'b0100011, 3'b010, 1'b0, 5'd9, 5'd0, 5'd2, 32'd8, 32'h0020_2423);
    send("beq",  3'b010, 7'b1100011, 3'b000, 1'b0, 5'd0, 5'd1, 5'd2, 32'd8, 32'h0020_8463);
    send("jal",  3'b011, 7'b1101111, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 32'd16, 32'h0100_00EF);
    send("lui",  3'b100, 7'b0110111, 3'b000, 1'b0, 5'd5, 5'd0, 5'd0, 32'h1234_5000, 32'h1234_52B7);
    send("bne_neg", 3'b010, 7'b1100011, 3'b001, 1'b0, 5'd0, 5'd0, 5'd0, 32'hFFFF_FFFC, 32'hFE00_1EE3);
    send("jal_neg", 3'b011, 7'b1101111, 3'b000, 1'b0, 5'd0, 5'd0, 5'd0, 32'hFFFF_FFF8, 32'hFF9F_F06F);
    send("sra",  3'b101, 7'b0110011, 3'b101, 1'b1, 5'd5, 5'd6, 5'd7, 32'h0, 32'h4073_52B3);
    send("addi_junk", 3'b000, 7'b0010011, 3'b000, 1'b1, 5'd2, 5'd3, 5'd31, 32'hFFFF_F7FF, 32'h7FF1_8113);
    chk("err_before_illegal", 32'(cur_err), 0);
    send("illegal111", 3'b111, 7'b0110011, 3'b000, 1'b1, 5'd3, 5'd1, 5'd2, 32'h1234_5678, 32'h0000_0013);
    chk("err_set", 32'(cur_err), 1);
    send("illegal110", 3'b110, 7'b0010011, 3'b111, 1'b0, 5'd7, 5'd7, 5'd7, 32'hFFFF_FFFF, 32'h0000_0013);
    send("lui_after_err", 3'b100, 7'b0110111, 3'b000, 1'b0, 5'd5, 5'd0, 5'd0, 32'h1234_5000, 32'h1234_52B7);
    vld = 1'b0;
    chk("err_sticky", 32'(cur_err), 1);
    chk("count_14", cur_cnt, 14);

    pulse_finish();
    chk("finish_busy", 32'(cur_busy), 0);
    chk("finish_ready", 32'(cur_rdy), 0);
    chk("err_after_finish", 32'(cur_err), 1);
    pulse_start();
    chk("err_cleared", 32'(cur_err), 0);
    chk("count_cleared", cur_cnt, 0);

    // finish in the same cycle as an accept: write still happens, then IDLE.
    finish = 1'b1;
    send("finish_accept", 3'b000, 7'b0010011, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5, 32'h0050_0093);
    finish = 1'b0; vld = 1'b0;
    chk("finish_accept_busy", 32'(cur_busy), 0);
    chk("finish_accept_count", cur_cnt, 1);

    // Reset while a write is on the memory port.
    pulse_start();
    send("pre_reset", 3'b100, 7'b0110111, 3'b000, 1'b0, 5'd5, 5'd0, 5'd0, 32'h1234_5000, 32'h1234_52B7);
    vld = 1'b0;
    #1 reset = 1'b1;
    #1;
    chk("async_rst_we", 32'(we_a), 0);
    chk("async_rst_count", 32'(cnt_a), 0);
    chk("async_rst_busy", 32'(busy_a), 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("post_rst_ready", 32'(ifa.in_ready), 0);
    end

    // Four-word instance: fill-up, stall, finish and restart from FULL.
    sel = 1'b1;
    @(negedge clk);
    pulse_start();
    for (int i = 0; i < 4; i++)
      send("fill", 3'b000, 7'b0010011, 3'b000, 1'b0, 5'(i + 1), 5'd0, 5'd0, 32'(i), fill_exp[i]);
    chk("fill_full", 32'(cur_full), 1);
    chk("fill_ready", 32'(cur_rdy), 0);
    chk("fill_count", cur_cnt, 4);
    chk("fill_busy", 32'(cur_busy), 1);
    rd = 5'd5; imm = 32'd4;
    repeat (4) begin
      @(negedge clk);
      chk("stall_ready", 32'(cur_rdy), 0);
    end
    vld = 1'b0;
    chk("stall_count", cur_cnt, 4);
    pulse_finish();
    chk("full_finish_busy", 32'(cur_busy), 0);
    chk("full_finish_full", 32'(cur_full), 0);

    pulse_start();
    for (int i = 0; i < 4; i++)
      send("refill", 3'b000, 7'b0010011, 3'b000, 1'b0, 5'(i + 1), 5'd0, 5'd0, 32'(i), fill_exp[i]);
    vld = 1'b0;
    chk("refill_full", 32'(cur_full), 1);
    pulse_start();
    chk("restart_full", 32'(cur_full), 0);
    chk("restart_busy", 32'(cur_busy), 1);
    chk("restart_count", cur_cnt, 0);
    chk("restart_ready", 32'(cur_rdy), 1);
    send("restart_word", 3'b101, 7'b0110011, 3'b000, 1'b0, 5'd3, 5'd1, 5'd2, 32'h0, 32'h0020_81B3);
    vld = 1'b0;
    chk("restart_count1", cur_cnt, 1);
    pulse_finish();

    repeat (2) @(negedge clk);
    chk("a_queue_drained", 32'(qa.size()), 0);
    chk("b_queue_drained", 32'(qb.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
